ctr_sequencer: RTL and testbench
================================

# ctr_sequencer

Multi-channel capture sequencer, the parametrised successor of the single-channel capture controller. It steps through the enabled channels, one per pass. For each channel it issues a datapath reset pulse, drives an enable window and write address over the capture RAM, then hands off to the transfer engine and waits for `transfer_done`. It supports single-shot and continuous modes and sits between the push-button start logic and the RAM/transfer datapath in the `variable_clk_2` domain.

## Interface
- `ADDR_WIDTH`, 14, write-address width
- `RAM_DEPTH`, 16384, capture RAM depth; one fill writes `RAM_DEPTH-2` samples
- `NUM_CH`, 4, number of channels (1..16)
- `CH_WIDTH`, 2, channel index width, ≥ clog2(`NUM_CH`)
- `TIMEOUT_CYCLES`, 65535, transfer watchdog limit; used only with `CTR_XFER_TIMEOUT_EN`
- `variable_clk_2`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start_req`  in  1  one-cycle start pulse, already synchronised
- `stop_req`  in  1  one-cycle pulse; ends continuous mode after the current pass
- `mode`  in  1  0 = single-shot, 1 = continuous; sampled on accepted start
- `ch_mask`  in  `NUM_CH`  enabled channels; sampled on accepted start
- `transfer_done`  in  1  one-cycle pulse from the transfer engine
- `enable`  out  1  capture write enable
- `enable_2`  out  1  `enable` delayed by one cycle
- `wr_addr`  out  `ADDR_WIDTH`  capture RAM write address
- `ch_sel`  out  `CH_WIDTH`  active channel index
- `pipe_rst`  out  1  one-cycle datapath reset pulse, issued before each fill
- `xfer_req`  out  1  transfer request; held high until `transfer_done`
- `busy`  out  1  high whenever the FSM is not in IDLE
- `pass_count`  out  16  completed full passes, wraps at 0xFFFF
- `xfer_err`  out  1  sticky watchdog error flag; constant 0 without the macro

## Operation
- FSM states: IDLE, CLEAR, FILL, FLUSH, XFER, NEXT.
- IDLE → CLEAR on `start_req` with `ch_mask != 0`.
  - On that transition: latch `mode` and `ch_mask`; set `ch_sel` = lowest set bit.
  - `start_req` is ignored if the mask is zero or `busy` is high.
- CLEAR: `pipe_rst`=1 for exactly one cycle; `wr_addr`←0; → FILL.
- FILL: `enable`=1.
  - `wr_addr` increments each cycle from 0 to `RAM_DEPTH-3`.
  - On the cycle after `wr_addr` = `RAM_DEPTH-3`: `enable`←0, → FLUSH.
- FLUSH: one cycle, so `enable_2` can drop; → XFER with `xfer_req`←1.
- XFER: wait for `transfer_done`; then `xfer_req`←0, → NEXT.
- NEXT:
  - If a higher set bit remains in the latched mask: `ch_sel`← that index, → CLEAR.
  - Otherwise the pass is complete: `pass_count`+1.
    - Continuous mode with no stop pending: `ch_sel`← lowest set bit, → CLEAR.
    - Otherwise → IDLE.
- `stop_req` in any non-IDLE state sets a stop-pending flag. The flag is cleared on entering IDLE. `stop_req` in IDLE is ignored.
- `transfer_done` outside XFER is ignored.
- `wr_addr` uses `ADDR_WIDTH`-bit unsigned arithmetic and never wraps inside FILL.

## Timing
- Reset values:
  - `enable`, `enable_2`, `pipe_rst`, `xfer_req`, `busy`, `xfer_err` = 0
  - `wr_addr`, `ch_sel`, `pass_count` = 0
  - state = IDLE, stop-pending = 0
- `reset` mid-operation aborts immediately. No `xfer_req` is held across reset.
- All outputs are registered.
- `start_req` at cycle t → `busy`=1 and `pipe_rst`=1 at t+1 → `enable`=1 at t+2.
- `enable` stays high for exactly `RAM_DEPTH-2` cycles per channel. `enable_2` equals `enable` delayed by one cycle.
- `transfer_done` at cycle t → `xfer_req`=0 at t+1. The next channel's `pipe_rst` follows at t+2.
- Simultaneous `start_req` and `reset`: reset wins. Simultaneous `stop_req` and `start_req` in IDLE: the start is accepted and the stop is ignored.

## Configuration
- `CTR_XFER_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles spent in XFER.
  - If `TIMEOUT_CYCLES` is reached with no `transfer_done`: `xfer_err`←1 (sticky until reset), `xfer_req`←0, FSM → IDLE, `pass_count` unchanged.
- `CTR_XFER_TIMEOUT_EN` undefined: no watchdog logic; `xfer_err` is tied to 0; XFER waits indefinitely.

## Test plan
- Single-shot: `RAM_DEPTH`=16, `ch_mask`=4'b0101, start, `transfer_done` 5 cycles after each `xfer_req` → `ch_sel` sequence 0 then 2; 14 `enable` cycles per channel; 2 `pipe_rst` pulses; `pass_count`=1; `busy`=0 at the end.
- Continuous: `mode`=1, `ch_mask`=4'b0001, `stop_req` during the 3rd FILL → exactly 3 passes; `pass_count`=3; returns to IDLE.
- Ignored events: `ch_mask`=0 with start → `busy` stays 0. A second `start_req` and a stray `transfer_done` during FILL → no effect on `wr_addr` sequence or state.
- Reset mid-FILL at `wr_addr`=7 → next cycle all outputs at reset values; a new start then runs a full 14-cycle fill.
- Timeout (macro on, `TIMEOUT_CYCLES`=20): never pulse `transfer_done` → after 20 XFER cycles `xfer_err`=1, `xfer_req`=0, `busy`=0, `pass_count`=0.
- `enable_2` check: across every run, `enable_2`(t) == `enable`(t-1), with no overlap of `pipe_rst` and `enable`.

Source files
------------

// File: rtl/ctr_sequencer.sv
// Multi-channel capture sequencer: per enabled channel runs clear -> fill -> flush -> transfer handshake.
// Optional transfer watchdog enabled by defining CTR_XFER_TIMEOUT_EN.
module ctr_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned RAM_DEPTH      = 16384,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CH_WIDTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  variable_clk_2,
  input  logic                  reset,
  input  logic                  start_req,
  input  logic                  stop_req,
  input  logic                  mode,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic                  transfer_done,
  output logic                  enable,
  output logic                  enable_2,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [CH_WIDTH-1:0]   ch_sel,
  output logic                  pipe_rst,
  output logic                  xfer_req,
  output logic                  busy,
  output logic [15:0]           pass_count,
  output logic                  xfer_err
);

  localparam int unsigned PC_WIDTH = 16;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 3);

  // Elaboration-time parameter sanity checks
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("ctr_sequencer: NUM_CH must be 1..16");
  end
  if (NUM_CH > (1 << CH_WIDTH)) begin : g_bad_ch_width
    $error("ctr_sequencer: CH_WIDTH too small for NUM_CH");
  end
  if (RAM_DEPTH < 3 || RAM_DEPTH - 3 >= (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("ctr_sequencer: RAM_DEPTH does not fit ADDR_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ctr_sequencer: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    FLUSH = 3'd3,
    XFER  = 3'd4,
    NEXT  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic                  stop_q, stop_d;
  logic                  enable_q, enable_d;
  logic                  enable_2_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CH_WIDTH-1:0]   ch_sel_q, ch_sel_d;
  logic                  pipe_rst_q, pipe_rst_d;
  logic                  xfer_req_q, xfer_req_d;
  logic                  busy_q;
  logic [PC_WIDTH-1:0]   pass_count_q, pass_count_d;

  logic [CH_WIDTH-1:0]   start_ch, first_ch, next_ch;
  logic                  has_next;

`ifdef CTR_XFER_TIMEOUT_EN
  localparam int unsigned WD_WIDTH = 16;
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [WD_WIDTH-1:0]   wd_q, wd_d;
  logic                  xfer_err_q, xfer_err_d;
`endif

  // Lowest set bit of the incoming and latched masks, and next set bit above ch_sel
  always_comb begin : find_channels
    start_ch = '0;
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) start_ch = CH_WIDTH'(i);
      if (mask_q[i]) first_ch = CH_WIDTH'(i);
      if (mask_q[i] && (i > int'(ch_sel_q))) begin
        has_next = 1'b1;
        next_ch  = CH_WIDTH'(i);
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    mode_d       = mode_q;
    mask_d       = mask_q;
    stop_d       = stop_q | (stop_req && (state_q != IDLE));
    enable_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    ch_sel_d     = ch_sel_q;
    pipe_rst_d   = 1'b0;
    xfer_req_d   = xfer_req_q;
    pass_count_d = pass_count_q;
`ifdef CTR_XFER_TIMEOUT_EN
    wd_d         = wd_q;
    xfer_err_d   = xfer_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_req && (ch_mask != '0)) begin
          state_d    = CLEAR;
          mode_d     = mode;
          mask_d     = ch_mask;
          ch_sel_d   = start_ch;
          pipe_rst_d = 1'b1;
          wr_addr_d  = '0;
        end
      end
      CLEAR: begin
        state_d   = FILL;
        enable_d  = 1'b1;
        wr_addr_d = '0;
      end
      FILL: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d = FLUSH;
        end else begin
          enable_d  = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end
      end
      FLUSH: begin
        state_d    = XFER;
        xfer_req_d = 1'b1;
`ifdef CTR_XFER_TIMEOUT_EN
        wd_d       = '0;
`endif
      end
      XFER: begin
        if (transfer_done) begin
          xfer_req_d = 1'b0;
          state_d    = NEXT;
`ifdef CTR_XFER_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          xfer_err_d = 1'b1;
          xfer_req_d = 1'b0;
          state_d    = IDLE;
        end else begin
          wd_d = wd_q + WD_WIDTH'(1);
`endif
        end
      end
      NEXT: begin
        if (has_next) begin
          state_d    = CLEAR;
          ch_sel_d   = next_ch;
          pipe_rst_d = 1'b1;
          wr_addr_d  = '0;
        end else begin
          pass_count_d = pass_count_q + PC_WIDTH'(1);
          if (mode_q && !stop_d) begin
            state_d    = CLEAR;
            ch_sel_d   = first_ch;
            pipe_rst_d = 1'b1;
            wr_addr_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A pending stop is consumed by returning to IDLE
    if (state_d == IDLE) stop_d = 1'b0;
  end

  always_ff @(posedge variable_clk_2) begin : regs
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      mask_q       <= '0;
      stop_q       <= 1'b0;
      enable_q     <= 1'b0;
      enable_2_q   <= 1'b0;
      wr_addr_q    <= '0;
      ch_sel_q     <= '0;
      pipe_rst_q   <= 1'b0;
      xfer_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      pass_count_q <= '0;
`ifdef CTR_XFER_TIMEOUT_EN
      wd_q         <= '0;
      xfer_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      stop_q       <= stop_d;
      enable_q     <= enable_d;
      enable_2_q   <= enable_q;
      wr_addr_q    <= wr_addr_d;
      ch_sel_q     <= ch_sel_d;
      pipe_rst_q   <= pipe_rst_d;
      xfer_req_q   <= xfer_req_d;
      busy_q       <= (state_d != IDLE);
      pass_count_q <= pass_count_d;
`ifdef CTR_XFER_TIMEOUT_EN
      wd_q         <= wd_d;
      xfer_err_q   <= xfer_err_d;
`endif
    end
  end

  assign enable     = enable_q;
  assign enable_2   = enable_2_q;
  assign wr_addr    = wr_addr_q;
  assign ch_sel     = ch_sel_q;
  assign pipe_rst   = pipe_rst_q;
  assign xfer_req   = xfer_req_q;
  assign busy       = busy_q;
  assign pass_count = pass_count_q;
`ifdef CTR_XFER_TIMEOUT_EN
  assign xfer_err   = xfer_err_q;
`else
  assign xfer_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ctr_sequencer.sv
// Directed bench for ctr_sequencer with RAM_DEPTH=16 (14-sample fills) and TIMEOUT_CYCLES=20.
module tb_ctr_sequencer;

  localparam int unsigned AW = 14;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_req, stop_req, mode, transfer_done;
  logic [NC-1:0] ch_mask;
  logic          enable, enable_2, pipe_rst, xfer_req, busy, xfer_err;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] ch_sel;
  logic [15:0]   pass_count;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt = 0;
  int n_pipe = 0;
  int exp_addr = 0;
  int ch_log [8];
  logic prev_en = 1'b0;
  logic rst_edge = 1'b1;

  ctr_sequencer #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(16), .NUM_CH(NC), .CH_WIDTH(CW), .TIMEOUT_CYCLES(20)
  ) dut (
    .variable_clk_2(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req),
    .mode(mode), .ch_mask(ch_mask), .transfer_done(transfer_done),
    .enable(enable), .enable_2(enable_2), .wr_addr(wr_addr), .ch_sel(ch_sel),
    .pipe_rst(pipe_rst), .xfer_req(xfer_req), .busy(busy), .pass_count(pass_count),
    .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_edge <= reset;

  // Continuous monitor: enable_2 delay, pipe_rst/enable exclusion, fill address sequence
  always @(negedge clk) begin
    if (!rst_edge) begin
      n_checks++;
      if (enable_2 !== prev_en) begin
        n_errors++;
        $display("FAIL enable_2_delay: got %b expected %b at %0t", enable_2, prev_en, $time);
      end
      n_checks++;
      if ((pipe_rst === 1'b1) && (enable === 1'b1)) begin
        n_errors++;
        $display("FAIL pipe_rst_enable_overlap: got both high expected exclusive at %0t", $time);
      end
      if (pipe_rst === 1'b1) begin
        if (n_pipe < 8) ch_log[n_pipe] = int'(ch_sel);
        n_pipe++;
        exp_addr = 0;
      end
      if (enable === 1'b1) begin
        n_checks++;
        if (wr_addr !== AW'(exp_addr)) begin
          n_errors++;
          $display("FAIL wr_addr_seq: got %0d expected %0d at %0t", wr_addr, exp_addr, $time);
        end
        exp_addr++;
        en_cnt++;
      end
    end
    prev_en = enable;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start_req = 1'b0; stop_req = 1'b0; mode = 1'b0;
    ch_mask = '0; transfer_done = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    en_cnt = 0; n_pipe = 0;
  endtask

  task automatic start(input logic [NC-1:0] m, input logic md);
    ch_mask = m; mode = md; start_req = 1'b1;
    cyc();
    start_req = 1'b0;
  endtask

  task automatic wait_xfer(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (xfer_req === 1'b1) ok = 1'b1;
      else cyc();
    end
  endtask

  // transfer_done five cycles after xfer_req is seen; returns on the cycle xfer_req should drop
  task automatic respond();
    repeat (5) cyc();
    transfer_done = 1'b1;
    cyc();
    transfer_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    n_checks++;
    if ({enable, enable_2, pipe_rst, xfer_req, busy, xfer_err} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {enable, enable_2, pipe_rst, xfer_req, busy, xfer_err});
    end
    n_checks++;
    if ({wr_addr, ch_sel, pass_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got addr=%0d ch=%0d pc=%0d expected 0/0/0", wr_addr, ch_sel, pass_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_shot();
    bit ok;
    do_reset();
    start(4'b0101, 1'b0);
    n_checks++;
    if ({busy, pipe_rst, ch_sel} !== {1'b1, 1'b1, 2'd0}) begin
      n_errors++;
      $display("FAIL ss_start_latency: got busy=%b pipe_rst=%b ch=%0d expected 1 1 0", busy, pipe_rst, ch_sel);
    end
    cyc();
    n_checks++;
    if ({enable, pipe_rst, wr_addr} !== {1'b1, 1'b0, 14'd0}) begin
      n_errors++;
      $display("FAIL ss_fill_start: got en=%b pr=%b addr=%0d expected 1 0 0", enable, pipe_rst, wr_addr);
    end
    wait_xfer(ok);
    n_checks++;
    if (!ok || en_cnt != 14) begin
      n_errors++;
      $display("FAIL ss_ch0_fill: got xfer=%b enables=%0d expected 1 14", ok, en_cnt);
    end
    respond();
    n_checks++;
    if (xfer_req !== 1'b0) begin
      n_errors++;
      $display("FAIL ss_xfer_drop: got %b expected 0", xfer_req);
    end
    cyc();
    n_checks++;
    if ({pipe_rst, ch_sel} !== {1'b1, 2'd2}) begin
      n_errors++;
      $display("FAIL ss_next_ch: got pr=%b ch=%0d expected 1 2", pipe_rst, ch_sel);
    end
    wait_xfer(ok);
    n_checks++;
    if (!ok || en_cnt != 28) begin
      n_errors++;
      $display("FAIL ss_ch2_fill: got xfer=%b enables=%0d expected 1 28", ok, en_cnt);
    end
    respond();
    cyc();
    n_checks++;
    if ({busy, xfer_req, pass_count} !== {1'b0, 1'b0, 16'd1}) begin
      n_errors++;
      $display("FAIL ss_end: got busy=%b xr=%b pc=%0d expected 0 0 1", busy, xfer_req, pass_count);
    end
    n_checks++;
    if (n_pipe != 2 || ch_log[0] != 0 || ch_log[1] != 2) begin
      n_errors++;
      $display("FAIL ss_ch_sequence: got pulses=%0d ch=%0d,%0d expected 2 0,2", n_pipe, ch_log[0], ch_log[1]);
    end
  endtask

  task automatic test_continuous();
    int  xfers = 0;
    bit  got;
    bit  stop_sent = 1'b0;
    do_reset();
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    ch_mask = 4'b0001; mode = 1'b1; start_req = 1'b1; stop_req = 1'b1;
    cyc();
    start_req = 1'b0; stop_req = 1'b0;
    for (int k = 0; k < 6 && busy === 1'b1; k++) begin
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        if (xfer_req === 1'b1) got = 1'b1;
        else begin
          if (!stop_sent && n_pipe == 3 && enable === 1'b1) begin
            stop_req = 1'b1;
            stop_sent = 1'b1;
          end
          cyc();
          stop_req = 1'b0;
        end
      end
      if (got) begin
        xfers++;
        respond();
        cyc();
      end
    end
    n_checks++;
    if (xfers != 3 || n_pipe != 3) begin
      n_errors++;
      $display("FAIL cont_passes: got xfers=%0d pulses=%0d expected 3 3", xfers, n_pipe);
    end
    n_checks++;
    if ({busy, pass_count} !== {1'b0, 16'd3}) begin
      n_errors++;
      $display("FAIL cont_end: got busy=%b pc=%0d expected 0 3", busy, pass_count);
    end
  endtask

  task automatic test_ignored();
    bit ok;
    do_reset();
    start(4'b0000, 1'b0);
    cyc();
    n_checks++;
    if ({busy, pipe_rst} !== 2'b00) begin
      n_errors++;
      $display("FAIL ign_zero_mask: got busy=%b pr=%b expected 0 0", busy, pipe_rst);
    end
    start(4'b0001, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (enable === 1'b1 && wr_addr === 14'd5) ok = 1'b1;
      else cyc();
    end
    ch_mask = 4'b1111; mode = 1'b1; start_req = 1'b1; transfer_done = 1'b1;
    cyc();
    start_req = 1'b0; transfer_done = 1'b0;
    n_checks++;
    if (!ok || {enable, wr_addr, xfer_req, ch_sel} !== {1'b1, 14'd6, 1'b0, 2'd0}) begin
      n_errors++;
      $display("FAIL ign_mid_fill: got reached=%b en=%b addr=%0d xr=%b ch=%0d expected 1 1 6 0 0",
               ok, enable, wr_addr, xfer_req, ch_sel);
    end
    wait_xfer(ok);
    n_checks++;
    if (!ok || en_cnt != 14) begin
      n_errors++;
      $display("FAIL ign_fill_len: got xfer=%b enables=%0d expected 1 14", ok, en_cnt);
    end
    respond();
    cyc();
    n_checks++;
    if ({busy, pass_count} !== {1'b0, 16'd1} || n_pipe != 1) begin
      n_errors++;
      $display("FAIL ign_end: got busy=%b pc=%0d pulses=%0d expected 0 1 1", busy, pass_count, n_pipe);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit ok = 1'b0;
    do_reset();
    start(4'b0100, 1'b1);
    for (int c = 0; c < 50 && !ok; c++) begin
      if (enable === 1'b1 && wr_addr === 14'd7) ok = 1'b1;
      else cyc();
    end
    reset = 1'b1;
    cyc();
    n_checks++;
    if (!ok || {enable, enable_2, pipe_rst, xfer_req, busy, xfer_err} !== 6'b0) begin
      n_errors++;
      $display("FAIL rst_mid_ctrl: got reached=%b ctrl=%b expected 1 000000",
               ok, {enable, enable_2, pipe_rst, xfer_req, busy, xfer_err});
    end
    n_checks++;
    if ({wr_addr, ch_sel, pass_count} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_values: got addr=%0d ch=%0d pc=%0d expected 0 0 0", wr_addr, ch_sel, pass_count);
    end
    reset = 1'b0;
    en_cnt = 0;
    cyc();
    start(4'b0001, 1'b0);
    wait_xfer(ok);
    n_checks++;
    if (!ok || en_cnt != 14) begin
      n_errors++;
      $display("FAIL rst_refill: got xfer=%b enables=%0d expected 1 14", ok, en_cnt);
    end
    respond();
    cyc();
    n_checks++;
    if ({busy, pass_count} !== {1'b0, 16'd1}) begin
      n_errors++;
      $display("FAIL rst_refill_end: got busy=%b pc=%0d expected 0 1", busy, pass_count);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    start(4'b0001, 1'b0);
    wait_xfer(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL to_xfer_seen: got %b expected 1", ok);
    end
`ifdef CTR_XFER_TIMEOUT_EN
    repeat (19) cyc();
    n_checks++;
    if ({xfer_err, xfer_req} !== 2'b01) begin
      n_errors++;
      $display("FAIL to_before_limit: got err=%b xr=%b expected 0 1", xfer_err, xfer_req);
    end
    cyc();
    n_checks++;
    if ({xfer_err, xfer_req, busy, pass_count} !== {3'b100, 16'd0}) begin
      n_errors++;
      $display("FAIL to_fired: got err=%b xr=%b busy=%b pc=%0d expected 1 0 0 0",
               xfer_err, xfer_req, busy, pass_count);
    end
    repeat (3) cyc();
    n_checks++;
    if (xfer_err !== 1'b1) begin
      n_errors++;
      $display("FAIL to_sticky: got %b expected 1", xfer_err);
    end
`else
    repeat (40) cyc();
    n_checks++;
    if ({xfer_req, busy, xfer_err} !== 3'b110) begin
      n_errors++;
      $display("FAIL no_to_wait: got xr=%b busy=%b err=%b expected 1 1 0", xfer_req, busy, xfer_err);
    end
    respond();
    cyc();
    n_checks++;
    if ({busy, pass_count} !== {1'b0, 16'd1}) begin
      n_errors++;
      $display("FAIL no_to_end: got busy=%b pc=%0d expected 0 1", busy, pass_count);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; start_req = 1'b0; stop_req = 1'b0; mode = 1'b0;
    ch_mask = '0; transfer_done = 1'b0;
    test_reset();
    test_single_shot();
    test_continuous();
    test_ignored();
    test_reset_mid_fill();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
